alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised ALU control + execute stage for the RISC-V datapath. Decodes ALUOp/Funct7/Funct3
//  into a 4-bit Operation and executes it on XLEN-bit operands behind a valid/ready handshake.
//  Adds shifts, SLTU and an iterative multi-cycle MUL (RV32M low word) to the base op set.
//  Sits between register-read and writeback; one operation in flight at a time.
// PARAMETERS
//  XLEN    32  operand/result width (>=8, power of 2)
//  MUL_EN  1   1 = MUL decoded and executed; 0 = funct7 0000001 flagged illegal
// PORTS
//  clk        in   1     rising-edge clock (single clock domain)
//  rst_n      in   1     asynchronous active-low reset
//  flush      in   1     synchronous abort of in-flight op
//  in_valid   in   1     request valid
//  in_ready   out  1     unit can accept request this cycle
//  alu_op     in   2     00 load/store ADD, 01 branch SUB, 10 R-type, 11 I-type
//  funct7     in   7     instr[31:25]
//  funct3     in   3     instr[14:12]
//  op_a       in   XLEN  operand A
//  op_b       in   XLEN  operand B (or sign-extended immediate)
//  out_valid  out  1     result valid, held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  ALU result
//  zero       out  1     result == 0
//  illegal    out  1     decode of captured request was illegal
//  operation  out  4     decoded Operation of captured request
// BEHAVIOUR
//  Operation codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1100,
//   SLL 1000, SRL 1001, SRA 1010, SLTU 1011, MUL 1101.
//  Decode: alu_op 00->ADD, 01->SUB regardless of funct. 10: funct3 selects op; funct7 0100000
//   legal only with 000 (SUB) / 101 (SRA); 0000001 with funct3 000 -> MUL (MUL_EN=1); other
//   funct7 != 0 -> illegal. 11: funct7 ignored except shifts (001 needs 0000000; 101 needs
//   0000000/0100000); never SUB/MUL.
//  Illegal: result=0, illegal=1, completes as a 1-cycle op.
//  Shift amount = op_b[$clog2(XLEN)-1:0]; SLT signed, SLTU unsigned; result 1/0 zero-extended.
//  ADD/SUB/MUL wrap modulo 2^XLEN; no overflow flag.
//  FSM: IDLE -> (accept, non-MUL) DONE; IDLE -> (accept, MUL) BUSY; BUSY -> DONE after XLEN
//   shift-add iterations (counter XLEN-1 down to 0); DONE -> (out_ready) IDLE, or straight to
//   DONE/BUSY if a new request is accepted the same cycle.
//  Accept = in_valid && in_ready; in_ready = (IDLE) || (DONE && out_ready); 0 in BUSY and
//   while flush=1.
//  Latency: non-MUL out_valid 1 cycle after accept; MUL out_valid XLEN+1 cycles after accept.
//   Back-to-back 1-cycle ops sustain 1 result/cycle when out_ready=1.
//  result/zero/illegal/operation registered; stable while out_valid && !out_ready.
//  flush: state->IDLE, out_valid->0 next edge; an in-flight MUL is discarded; flush wins over
//   a simultaneous accept.
//  Reset (async, any state incl. mid-MUL): state IDLE, out_valid 0, result 0, zero 1,
//   illegal 0, operation 0000, counter 0; in_ready 1 after reset release.
// STRUCTURE
//  Package alu_pkg: Operation code localparams, ALUOp encodings, funct7 constants, FSM
//   state typedef.
//  Sub-module alu_mul_seq: iterative shift-add multiplier (start/busy/done, XLEN cycles);
//   all other ops and decode stay in this module.
// TESTING (XLEN=32, MUL_EN=1)
//  R-type funct7=0100000 funct3=000, a=5, b=7 -> next cycle result=0xFFFFFFFE, op=0110, zero=0
//  I-type funct3=101 funct7=0100000, a=0x80000000, b=4 -> result 0xF8000000 (SRA), op=1010
//  MUL a=0xFFFFFFFF b=3 -> in_ready 0 for 32 cycles, out_valid at cycle 33, result 0xFFFFFFFD
//  SLT vs SLTU a=0xFFFFFFFF b=1 -> SLT result 1, SLTU result 0; ALUOp 01 a=b=9 -> zero=1
//  out_ready=0 for 5 cycles after valid -> result held, in_ready 0; R funct7=0000010 -> illegal=1
//  flush at MUL cycle 10, and rst_n low mid-MUL -> out_valid never asserts, IDLE, in_ready 1

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, ALUOp/funct7 encodings, FSM states and funct3 decode helper
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic sub, input logic sra);
    case (f3)
      3'b000:  return sub ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return sra ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier producing the low XLEN bits in XLEN cycles
module alu_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  // one partial product per cycle; done pulses the cycle after the last iteration
  always_comb begin
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      acc_d = '0;
      mcand_d = a;
      mplier_d = b;
      cnt_d = CW'(XLEN - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q - CW'(1);
      busy_d = cnt_q != '0;
      done_d = cnt_q == '0;
    end
  end
  // multiplier state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign product = acc_q;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU control decode plus execute stage with valid/ready handshake and sequential MUL
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [3:0]      operation
);
  localparam int SW = $clog2(XLEN);
  state_t state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, exec_res, mul_product;
  logic zero_q, zero_d, illegal_q, illegal_d, dec_ill, alt, accept, mul_start, mul_busy, mul_done;
  logic [3:0] operation_q, operation_d, dec_op;
  logic [SW-1:0] shamt;
  assign alt = funct7 == F7_ALT;
  assign shamt = op_b[SW-1:0];
  assign in_ready = !flush && !mul_busy && (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
  assign accept = in_valid && in_ready;
  // decode ALUOp/funct7/funct3; an illegal encoding reports operation 0000
  always_comb begin
    dec_op = OP_ADD;
    dec_ill = 1'b0;
    if (alu_op == ALUOP_BR) dec_op = OP_SUB;
    else if (alu_op != ALUOP_MEM) begin
      dec_op = f3_op(funct3, alt && alu_op == ALUOP_R, alt);
      if (alu_op == ALUOP_R) begin
        if (funct7 == F7_MULDIV) begin
          dec_op = OP_MUL;
          dec_ill = !(MUL_EN && funct3 == 3'b000);
        end else if (alt) dec_ill = !(funct3 == 3'b000 || funct3 == 3'b101);
        else dec_ill = funct7 != F7_BASE;
      end else if (funct3 == 3'b001) dec_ill = funct7 != F7_BASE;
      else if (funct3 == 3'b101) dec_ill = !(funct7 == F7_BASE || alt);
      if (dec_ill) dec_op = OP_AND;
    end
  end
  // single-cycle datapath for every operation except MUL
  always_comb begin
    case (dec_op)
      OP_AND:  exec_res = op_a & op_b;
      OP_OR:   exec_res = op_a | op_b;
      OP_ADD:  exec_res = op_a + op_b;
      OP_SUB:  exec_res = op_a - op_b;
      OP_SLT:  exec_res = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLTU: exec_res = XLEN'(op_a < op_b);
      OP_XOR:  exec_res = op_a ^ op_b;
      OP_SLL:  exec_res = op_a << shamt;
      OP_SRL:  exec_res = op_a >> shamt;
      OP_SRA:  exec_res = XLEN'($signed(op_a) >>> shamt);
      default: exec_res = '0;
    endcase
  end
  // FSM next state and registered result; flush overrides any accept
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    illegal_d = illegal_q;
    operation_d = operation_q;
    mul_start = 1'b0;
    if (flush) state_d = ST_IDLE;
    else if (accept) begin
      operation_d = dec_op;
      illegal_d = dec_ill;
      if (!dec_ill && dec_op == OP_MUL) begin
        state_d = ST_BUSY;
        mul_start = 1'b1;
      end else begin
        state_d = ST_DONE;
        result_d = dec_ill ? '0 : exec_res;
      end
    end else if (state_q == ST_BUSY && mul_done) begin
      state_d = ST_DONE;
      result_d = mul_product;
    end else if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
    zero_d = result_d == '0;
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      result_q <= '0;
      zero_q <= 1'b1;
      illegal_q <= 1'b0;
      operation_q <= OP_AND;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      zero_q <= zero_d;
      illegal_q <= illegal_d;
      operation_q <= operation_d;
    end
  end
  alu_mul_seq #(.XLEN(XLEN)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(mul_start),
    .abort(flush),
    .a(op_a),
    .b(op_b),
    .busy(mul_busy),
    .done(mul_done),
    .product(mul_product)
  );
  assign out_valid = state_q == ST_DONE;
  assign result = result_q;
  assign zero = zero_q;
  assign illegal = illegal_q;
  assign operation = operation_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for the ALU execute stage
module tb_alu_exec_unit;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, zero, illegal;
  logic [1:0] alu_op = '0;
  logic [6:0] funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0, result;
  logic [3:0] operation;
  typedef struct packed {logic [31:0] res; logic ill; logic [3:0] op;} exp_t;
  exp_t sb[$];
  exp_t mon_e, rnd_e;
  int n_chk = 0, n_fail = 0, lat;
  logic seen;
  logic [6:0] rf7;
  logic [2:0] rf3;
  logic [31:0] ra, rb;
  always #5 clk = ~clk;
  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .illegal(illegal), .operation(operation)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic send(input logic [1:0] ao, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                      input logic ei, input logic [3:0] eo, input bit push = 1'b1);
    int w = 0;
    @(negedge clk);
    alu_op = ao; funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("in_ready_timeout", in_ready, 1);
    if (push) sb.push_back('{res: er, ill: ei, op: eo});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  function automatic exp_t model_r(input logic [6:0] f7, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s = b[4:0];
    if (f7 == 7'h01) return '{res: a * b, ill: 1'b0, op: 4'hD};
    case (f3)
      3'd0: return f7[5] ? '{res: a - b, ill: 1'b0, op: 4'h6} : '{res: a + b, ill: 1'b0, op: 4'h2};
      3'd1: return '{res: a << s, ill: 1'b0, op: 4'h8};
      3'd2: return '{res: 32'($signed(a) < $signed(b)), ill: 1'b0, op: 4'h7};
      3'd3: return '{res: 32'(a < b), ill: 1'b0, op: 4'hB};
      3'd4: return '{res: a ^ b, ill: 1'b0, op: 4'hC};
      3'd5: return f7[5] ? '{res: 32'($signed(a) >>> s), ill: 1'b0, op: 4'hA} : '{res: a >> s, ill: 1'b0, op: 4'h9};
      3'd6: return '{res: a | b, ill: 1'b0, op: 4'h1};
      default: return '{res: a & b, ill: 1'b0, op: 4'h0};
    endcase
  endfunction
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("result", result, mon_e.res);
        chk("zero", zero, mon_e.res == 32'd0);
        chk("illegal", illegal, mon_e.ill);
        chk("operation", operation, mon_e.op);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_illegal", illegal, 0);
    chk("rst_operation", operation, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    send(2'b10, 7'h20, 3'd0, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 4'h6);
    send(2'b11, 7'h20, 3'd5, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 4'hA);
    send(2'b10, 7'h00, 3'd2, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 4'h7);
    send(2'b10, 7'h00, 3'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 4'hB);
    send(2'b01, 7'h7F, 3'd7, 32'd9, 32'd9, 32'd0, 1'b0, 4'h6);
    send(2'b10, 7'h02, 3'd0, 32'd5, 32'd7, 32'd0, 1'b1, 4'h0);
    send(2'b00, 7'h20, 3'd5, 32'hFFFFFFF0, 32'h20, 32'h10, 1'b0, 4'h2);
    send(2'b11, 7'h20, 3'd1, 32'd1, 32'd1, 32'd0, 1'b1, 4'h0);
    send(2'b11, 7'h20, 3'd0, 32'd10, 32'd3, 32'd13, 1'b0, 4'h2);
    send(2'b10, 7'h00, 3'd1, 32'd3, 32'h21, 32'd6, 1'b0, 4'h8);
    send(2'b10, 7'h00, 3'd5, 32'h80000000, 32'h1F, 32'd1, 1'b0, 4'h9);
    send(2'b10, 7'h01, 3'd1, 32'd2, 32'd3, 32'd0, 1'b1, 4'h0);
    send(2'b11, 7'h00, 3'd4, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 4'hC);
    send(2'b10, 7'h00, 3'd6, 32'hF0, 32'h0F, 32'hFF, 1'b0, 4'h1);
    send(2'b10, 7'h00, 3'd7, 32'hF0, 32'h3C, 32'h30, 1'b0, 4'h0);
    send(2'b11, 7'h55, 3'd6, 32'd1, 32'd2, 32'd3, 1'b0, 4'h1);
    send(2'b10, 7'h01, 3'd0, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b0, 4'hD);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
      if (!out_valid) chk("mul_busy_in_ready", in_ready, 0);
    end
    chk("mul_latency", lat, 33);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    send(2'b10, 7'h00, 3'd2, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 4'h7);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("hold_valid_timeout", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      rf7 = ((rf3 == 3'd0 || rf3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ($urandom_range(0, 7) == 0) begin
        rf3 = 3'd0;
        rf7 = 7'h01;
      end
      ra = $urandom;
      rb = $urandom;
      rnd_e = model_r(rf7, rf3, ra, rb);
      send(2'b10, rf7, rf3, ra, rb, rnd_e.res, rnd_e.ill, rnd_e.op);
    end
    repeat (40) @(negedge clk);
    send(2'b10, 7'h01, 3'd0, 32'd7, 32'd9, 32'd0, 1'b0, 4'h0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_op = 2'b00;
    #1 chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("flush_no_valid", seen, 0);
    chk("flush_in_ready_after", in_ready, 1);
    send(2'b10, 7'h01, 3'd0, 32'd7, 32'd9, 32'd0, 1'b0, 4'h0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_zero", zero, 1);
    chk("rst_mid_operation", operation, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("rst_mid_no_valid", seen, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
